// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
  localparam int ZERO_REG      = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: write ports clear, alloc sets (set wins), x0 never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_rd,
  output logic [NREGS-1:0]     busy,
  output logic                 any_busy
);
  logic [NREGS-1:0] busy_next;
  logic [AW-1:0]    wa;

  always_comb begin
    busy_next = busy;
    wa        = '0;
    for (int unsigned p = 0; p < NWRITE; p++) begin
      wa = wr_addr[p*AW +: AW];
      if (wr_en[p] && wa != AW'(ZERO_REG))
        busy_next[wa] = 1'b0;
    end
    // Applied after the clears so a new producer outranks a retiring one.
    if (alloc_en && alloc_rd != AW'(ZERO_REG))
      busy_next[alloc_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else if (!stall)
      busy <= busy_next;
  end

  assign any_busy = |busy;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with busy scoreboard; x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding under REGFILE_MP_SB_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_rd,
  output logic                   any_busy
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .alloc_en (alloc_en),
    .alloc_rd (alloc_rd),
    .busy     (busy),
    .any_busy (any_busy)
  );

  // Ascending port order: the last non-blocking write (highest port) wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (!stall) begin
      for (int unsigned p = 0; p < NWRITE; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] != AW'(ZERO_REG))
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
    end
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rdat;
  logic            rbsy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbsy    = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra   = rd_addr[i*AW +: AW];
      rdat = regs[ra];
      rbsy = busy[ra];
`ifdef REGFILE_MP_SB_BYPASS_EN
      for (int unsigned p = 0; p < NWRITE; p++)
        if (!stall && wr_en[p] && ra != AW'(ZERO_REG) && wr_addr[p*AW +: AW] == ra) begin
          rdat = wr_data[p*XLEN +: XLEN];
          rbsy = alloc_en && (alloc_rd == ra);
        end
`endif
      rd_data[i*XLEN +: XLEN] = rdat;
      rd_busy[i]              = rbsy;
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic vs. an array model.
module tb_regfile_mp_sb;
  logic        clk = 1'b0;
  logic        reset, stall;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic        any_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_mp_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle();
    reset = 1'b0; stall = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_rd = '0;
  endtask

  // One clock edge; the model commits exactly what the spec says happens at that edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    end else if (!stall) begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*5 +: 5] != 0) begin
          m_regs[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
          m_busy[wr_addr[p*5 +: 5]] = 1'b0;
        end
      if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] d = m_regs[a];
`ifdef REGFILE_MP_SB_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (!stall && a != 0 && wr_en[p] && wr_addr[p*5 +: 5] == a) d = wr_data[p*32 +: 32];
`endif
    return d;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b = m_busy[a];
`ifdef REGFILE_MP_SB_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (!stall && a != 0 && wr_en[p] && wr_addr[p*5 +: 5] == a) b = alloc_en && alloc_rd == a;
`endif
    return b;
  endfunction

  function automatic logic exp_any();
    logic o = 1'b0;
    for (int r = 0; r < 32; r++) o = o | m_busy[r];
    return o;
  endfunction

  task automatic do_reset();
    idle(); reset = 1'b1; cycle(); idle();
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)}; #1;
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
        errors++; $display("FAIL reset_read a=%0d data=%h busy=%b want 0/00", a, rd_data, rd_busy);
      end
    end
    checks++;
    if (any_busy !== 1'b0) begin errors++; $display("FAIL reset_any_busy got %b want 0", any_busy); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    cycle(); idle(); rd_addr = {5'd0, 5'd5}; #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_x5 got %h want deadbeef", rd_data[31:0]);
    end
    reset = 1'b1; alloc_en = 1'b1; alloc_rd = 5'd6;
    wr_en = 2'b10; wr_addr = {5'd5, 5'd0}; wr_data = {32'h12345678, 32'd0};
    cycle(); idle(); rd_addr = {5'd6, 5'd5}; #1;
    checks++;
    if (rd_data[31:0] !== 32'd0 || any_busy !== 1'b0 || rd_busy[1] !== 1'b0) begin
      errors++; $display("FAIL midreset x5=%h any_busy=%b busy6=%b want 0/0/0", rd_data[31:0], any_busy, rd_busy[1]);
    end
  endtask

  task automatic test_x0();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wr_en = 2'b11; wr_addr = '0; wr_data = '1; alloc_en = 1'b1; alloc_rd = 5'd0;
      rd_addr = '0; #1;
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
        errors++; $display("FAIL x0_live k=%0d data=%h busy=%b want 0/00", k, rd_data, rd_busy);
      end
      cycle();
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00 || any_busy !== 1'b0) begin
        errors++; $display("FAIL x0_after k=%0d data=%h busy=%b any=%b want 0/00/0", k, rd_data, rd_busy, any_busy);
      end
    end
    idle();
  endtask

  task automatic test_collision();
    do_reset();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    cycle(); idle(); rd_addr = {5'd7, 5'd7}; #1;
    checks++;
    if (rd_data !== {32'h22, 32'h22}) begin
      errors++; $display("FAIL collision x7 got %h want 22 on both ports", rd_data);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    alloc_en = 1'b1; alloc_rd = 5'd9;
    cycle(); idle(); rd_addr = {5'd0, 5'd9}; #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || any_busy !== 1'b1) begin
      errors++; $display("FAIL alloc_x9 busy=%b any=%b want 1/1", rd_busy[0], any_busy);
    end
    alloc_en = 1'b1; alloc_rd = 5'd9;
    cycle(); idle(); #1;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h1234, 32'd0};
    cycle(); idle(); #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h1234 || any_busy !== 1'b0) begin
      errors++; $display("FAIL clear_x9 busy=%b data=%h any=%b want 0/1234/0", rd_busy[0], rd_data[31:0], any_busy);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h77};
    alloc_en = 1'b1; alloc_rd = 5'd9;
    cycle(); idle(); #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h77) begin
      errors++; $display("FAIL alloc_wins busy=%b data=%h want 1/77", rd_busy[0], rd_data[31:0]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hA5};
    alloc_en = 1'b1; alloc_rd = 5'd4;
    cycle(); stall = 1'b0; wr_en = '0; alloc_en = 1'b0; rd_addr = {5'd4, 5'd3}; #1;
    checks++;
    if (rd_data[31:0] !== 32'd0 || rd_busy[1] !== 1'b0 || any_busy !== 1'b0) begin
      errors++; $display("FAIL stall_hold x3=%h busy4=%b any=%b want 0/0/0", rd_data[31:0], rd_busy[1], any_busy);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hA5};
    alloc_en = 1'b1; alloc_rd = 5'd4;
    cycle(); idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'hA5 || rd_busy[1] !== 1'b1) begin
      errors++; $display("FAIL stall_release x3=%h busy4=%b want a5/1", rd_data[31:0], rd_busy[1]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h11};
    cycle(); idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h55};
    rd_addr = {5'd0, 5'd10}; #1;
    checks++;
`ifdef REGFILE_MP_SB_BYPASS_EN
    if (rd_data[31:0] !== 32'h55) begin
      errors++; $display("FAIL bypass_same_cycle got %h want 55", rd_data[31:0]);
    end
`else
    if (rd_data[31:0] !== 32'h11) begin
      errors++; $display("FAIL nobypass_same_cycle got %h want 11", rd_data[31:0]);
    end
`endif
    cycle(); idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'h55) begin
      errors++; $display("FAIL bypass_next_cycle got %h want 55", rd_data[31:0]);
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 9) == 0);
      wr_en    = 2'($urandom);
      wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data  = {$urandom, $urandom};
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_rd = 5'($urandom_range(0, 7));
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int i = 0; i < 2; i++) begin
        a = rd_addr[i*5 +: 5];
        checks++;
        if (rd_data[i*32 +: 32] !== exp_data(a) || rd_busy[i] !== exp_busy(a)) begin
          errors++;
          $display("FAIL random n=%0d port=%0d addr=%0d data=%h busy=%b want %h/%b",
                   n, i, a, rd_data[i*32 +: 32], rd_busy[i], exp_data(a), exp_busy(a));
        end
      end
      checks++;
      if (any_busy !== exp_any()) begin
        errors++; $display("FAIL random_any n=%0d got %b want %b", n, any_busy, exp_any());
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    rd_addr = '0;
    for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    @(negedge clk);
    test_reset();
    test_x0();
    test_collision();
    test_scoreboard();
    test_stall();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
